// File: rtl/l1_icache_nway.sv
// l1_icache_nway: N-way set-associative L1 instruction cache with blocking refill, invalidate and flush
module l1_icache_nway #(
    parameter int FETCH_WIDTH = 4,
    parameter int NUM_WAYS    = 2,
    parameter int NUM_SETS    = 64,
    parameter int LINE_BYTES  = 32,
    parameter int PC_W        = 64,
    parameter int INST_W      = 32,
    localparam int OFF = $clog2(LINE_BYTES),
    localparam int IDX = $clog2(NUM_SETS),
    localparam int TAG = PC_W - OFF - IDX,
    localparam int WB  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int LW  = 8 * LINE_BYTES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetchReq_i,
    input  logic [PC_W-1:0]               pc_i,
    input  logic [FETCH_WIDTH-1:0]        fetchLaneActive_i,
    output logic [FETCH_WIDTH*INST_W-1:0] inst_o,
    output logic [FETCH_WIDTH-1:0]        instValid_o,
    output logic                          icMiss_o,
    output logic                          ic2memReqValid_o,
    output logic [PC_W-OFF-1:0]           ic2memReqAddr_o,
    output logic [WB-1:0]                 ic2memReqWay_o,
    input  logic                          mem2icRespValid_i,
    input  logic [TAG-1:0]                mem2icTag_i,
    input  logic [IDX-1:0]                mem2icIndex_i,
    input  logic [LW-1:0]                 mem2icData_i,
    input  logic                          mem2icInv_i,
    input  logic [IDX-1:0]                mem2icInvInd_i,
    input  logic                          icFlush_i,
    output logic                          icFlushDone_o
);
    localparam int WORDS = LINE_BYTES / 4;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL, S_FLUSH} state_t;
    logic [LW-1:0]                 r_data [NUM_WAYS][NUM_SETS];
    logic [TAG-1:0]                r_tag  [NUM_WAYS][NUM_SETS];
    logic [NUM_SETS-1:0]           r_vld  [NUM_WAYS];
    logic [WB-1:0]                 r_rr   [NUM_SETS];
    state_t                        r_state, w_next;
    logic [TAG-1:0]                r_mtag;
    logic [IDX-1:0]                r_midx, r_fcnt;
    logic [WB-1:0]                 r_mway;
    logic [LW-1:0]                 r_fdata;
    logic                          r_fpend, r_req, r_done;
    logic [FETCH_WIDTH*INST_W-1:0] r_inst, w_lanes;
    logic [FETCH_WIDTH-1:0]        r_ival, w_lval;
    logic [IDX-1:0]                w_idx;
    logic [TAG-1:0]                w_tag;
    logic [LW-1:0]                 w_line;
    logic                          w_hit, w_lookup, w_miss, w_resp;
    int                            w_woff;
    assign w_idx    = pc_i[OFF+IDX-1:OFF];
    assign w_tag    = pc_i[PC_W-1:OFF+IDX];
    assign w_woff   = int'(pc_i[OFF-1:0]) >> 2;
    assign w_lookup = (r_state == S_IDLE) && fetchReq_i;
    assign w_miss   = w_lookup && !w_hit;
    assign w_resp   = (r_state == S_WAIT) && mem2icRespValid_i && mem2icTag_i == r_mtag && mem2icIndex_i == r_midx;
    // tag compare across all ways of the addressed set
    always_comb begin
        w_hit  = 1'b0;
        w_line = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (r_vld[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit  = 1'b1;
                w_line = r_data[w][w_idx];
            end
    end
    // lane extraction; lanes past the end of the line are never valid
    always_comb begin
        w_lanes = '0;
        w_lval  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            if (w_woff + i < WORDS) begin
                w_lanes[i*INST_W +: INST_W] = w_line[(w_woff+i)*32 +: INST_W];
                w_lval[i] = fetchLaneActive_i[i];
            end
    end
    // FSM state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    // FSM next state; a miss in IDLE takes priority over a flush, which is then deferred
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_miss ? S_WAIT : (icFlush_i || r_fpend) ? S_FLUSH : S_IDLE;
            S_WAIT:  w_next = w_resp ? S_FILL : S_WAIT;
            S_FILL:  w_next = (icFlush_i || r_fpend) ? S_FLUSH : S_IDLE;
            S_FLUSH: w_next = (r_fcnt == IDX'(NUM_SETS-1)) ? S_IDLE : S_FLUSH;
        endcase
    end
    // FSM outputs
    always_comb begin
        icMiss_o         = (r_state == S_WAIT) || (r_state == S_FILL);
        ic2memReqValid_o = r_req;
        ic2memReqAddr_o  = {r_mtag, r_midx};
        ic2memReqWay_o   = r_mway;
        icFlushDone_o    = r_done;
        inst_o           = r_inst;
        instValid_o      = r_ival;
    end
    // miss bookkeeping, flush sequencing and registered fetch response
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_mtag  <= '0;
            r_midx  <= '0;
            r_mway  <= '0;
            r_fdata <= '0;
            r_fpend <= 1'b0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_fcnt  <= '0;
            r_inst  <= '0;
            r_ival  <= '0;
        end else begin
            r_req  <= w_miss;
            r_done <= (r_state == S_FLUSH) && (r_fcnt == IDX'(NUM_SETS-1));
            r_fcnt <= (r_state == S_FLUSH) ? r_fcnt + 1'b1 : '0;
            r_ival <= (w_lookup && w_hit) ? w_lval : '0;
            if (w_lookup && w_hit) r_inst <= w_lanes;
            if (w_miss) begin
                r_mtag <= w_tag;
                r_midx <= w_idx;
                r_mway <= r_rr[w_idx];
            end
            if (w_resp) r_fdata <= mem2icData_i;
            if (w_next == S_FLUSH) r_fpend <= 1'b0;
            else if (icFlush_i && r_state != S_FLUSH) r_fpend <= 1'b1;
        end
    // valid bits and round-robin pointers; fill is applied after invalidate so it wins
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int w = 0; w < NUM_WAYS; w++) r_vld[w] <= '0;
            for (int s = 0; s < NUM_SETS; s++) r_rr[s] <= '0;
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (mem2icInv_i) r_vld[w][mem2icInvInd_i] <= 1'b0;
                if (r_state == S_FLUSH) r_vld[w][r_fcnt] <= 1'b0;
            end
            if (r_state == S_FILL) begin
                r_vld[r_mway][r_midx] <= 1'b1;
                r_rr[r_midx] <= (r_rr[r_midx] == WB'(NUM_WAYS-1)) ? '0 : r_rr[r_midx] + 1'b1;
            end
        end
    // line data and tag storage
    always_ff @(posedge clk)
        if (r_state == S_FILL) begin
            r_data[r_mway][r_midx] <= r_fdata;
            r_tag[r_mway][r_midx]  <= r_mtag;
        end
endmodule

// File: tb/tb_l1_icache_nway.sv
// tb_l1_icache_nway: scoreboard bench for the N-way instruction cache
module tb_l1_icache_nway;
    localparam logic [1:0] HIT = 2'd0, MISS = 2'd1, IGN = 2'd2;
    typedef struct {
        int          due;
        logic [1:0]  kind;
        logic [3:0]  val;
        logic [127:0] inst;
        logic [58:0] addr;
        logic        way;
    } exp_t;
    logic         clk = 0, reset = 0, fetchReq_i = 0, mem2icRespValid_i = 0, mem2icInv_i = 0, icFlush_i = 0;
    logic [63:0]  pc_i = '0;
    logic [3:0]   fetchLaneActive_i = '0;
    logic [127:0] inst_o;
    logic [3:0]   instValid_o;
    logic         icMiss_o, ic2memReqValid_o, icFlushDone_o;
    logic [58:0]  ic2memReqAddr_o;
    logic [0:0]   ic2memReqWay_o;
    logic [52:0]  mem2icTag_i = '0;
    logic [5:0]   mem2icIndex_i = '0, mem2icInvInd_i = '0;
    logic [255:0] mem2icData_i = '0;
    int n_tests = 0, n_fail = 0, cyc = 0;
    exp_t sb[$];
    exp_t e;
    l1_icache_nway dut (
        .clk(clk), .reset(reset), .fetchReq_i(fetchReq_i), .pc_i(pc_i),
        .fetchLaneActive_i(fetchLaneActive_i), .inst_o(inst_o), .instValid_o(instValid_o),
        .icMiss_o(icMiss_o), .ic2memReqValid_o(ic2memReqValid_o), .ic2memReqAddr_o(ic2memReqAddr_o),
        .ic2memReqWay_o(ic2memReqWay_o), .mem2icRespValid_i(mem2icRespValid_i), .mem2icTag_i(mem2icTag_i),
        .mem2icIndex_i(mem2icIndex_i), .mem2icData_i(mem2icData_i), .mem2icInv_i(mem2icInv_i),
        .mem2icInvInd_i(mem2icInvInd_i), .icFlush_i(icFlush_i), .icFlushDone_o(icFlushDone_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    // memory model: word w of a line carries the low line-address bits and w
    function automatic logic [255:0] line_data(input logic [63:0] pc);
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = {pc[28:5], 8'(w)};
        return d;
    endfunction
    function automatic logic [127:0] exp_inst(input logic [63:0] pc);
        logic [127:0] r = '0;
        int woff = int'(pc[4:2]);
        for (int i = 0; i < 4; i++) if (woff + i < 8) r[i*32 +: 32] = {pc[28:5], 8'(woff + i)};
        return r;
    endfunction
    function automatic logic [127:0] lane_mask(input logic [3:0] v);
        logic [127:0] m = '0;
        for (int i = 0; i < 4; i++) if (v[i]) m[i*32 +: 32] = '1;
        return m;
    endfunction
    // scoreboard consumer: each fetch is checked one cycle after it was presented
    always @(negedge clk)
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_tests++;
            if (instValid_o !== e.val) begin
                n_fail++;
                $display("FAIL sb_valid kind=%0d got=%b exp=%b", e.kind, instValid_o, e.val);
            end
            if (e.kind == HIT) begin
                n_tests++;
                if ((inst_o & lane_mask(e.val)) !== (e.inst & lane_mask(e.val))) begin
                    n_fail++;
                    $display("FAIL sb_inst got=%h exp=%h", inst_o & lane_mask(e.val), e.inst & lane_mask(e.val));
                end
                n_tests++;
                if ({icMiss_o, ic2memReqValid_o} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL sb_hit_flags got=%b exp=00", {icMiss_o, ic2memReqValid_o});
                end
            end else if (e.kind == MISS) begin
                n_tests++;
                if ({icMiss_o, ic2memReqValid_o} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL sb_miss_flags got=%b exp=11", {icMiss_o, ic2memReqValid_o});
                end
                n_tests++;
                if (ic2memReqAddr_o !== e.addr || ic2memReqWay_o !== e.way) begin
                    n_fail++;
                    $display("FAIL sb_req addr=%h way=%0d exp addr=%h way=%0d", ic2memReqAddr_o, ic2memReqWay_o, e.addr, e.way);
                end
            end else begin
                n_tests++;
                if ({icMiss_o, ic2memReqValid_o} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL sb_ignored_flags got=%b exp=10", {icMiss_o, ic2memReqValid_o});
                end
            end
        end
    // present one fetch at a negedge, queue its expected response, return at the next negedge
    task automatic fetch(input logic [63:0] pc, input logic [3:0] mask, input logic [1:0] kind,
                         input logic [3:0] val, input logic way, input logic inv);
        exp_t x;
        fetchReq_i = 1; pc_i = pc; fetchLaneActive_i = mask;
        mem2icInv_i = inv; mem2icInvInd_i = pc[10:5];
        x.due = cyc + 1; x.kind = kind; x.val = val; x.inst = exp_inst(pc); x.addr = pc[63:5]; x.way = way;
        sb.push_back(x);
        @(negedge clk);
        fetchReq_i = 0; mem2icInv_i = 0;
    endtask
    // return the line for an outstanding miss, optionally invalidating the same set during FILL
    task automatic refill(input logic [63:0] pc, input logic inv_fill);
        mem2icRespValid_i = 1; mem2icTag_i = pc[63:11]; mem2icIndex_i = pc[10:5]; mem2icData_i = line_data(pc);
        @(negedge clk);
        mem2icRespValid_i = 0;
        n_tests++;
        if (icMiss_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_miss_high got=%b exp=1", icMiss_o);
        end
        mem2icInv_i = inv_fill; mem2icInvInd_i = pc[10:5];
        @(negedge clk);
        mem2icInv_i = 0;
        n_tests++;
        if (icMiss_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_miss_drop got=%b exp=0", icMiss_o);
        end
    endtask
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({icMiss_o, ic2memReqValid_o, icFlushDone_o, instValid_o, inst_o, ic2memReqAddr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs miss=%b req=%b done=%b val=%b exp all 0", icMiss_o, ic2memReqValid_o, icFlushDone_o, instValid_o);
        end
        reset = 1;
        @(negedge clk);
    endtask
    task automatic test_cold();
        fetch(64'h1000, 4'hf, MISS, 4'h0, 1'b0, 1'b0);
        mem2icRespValid_i = 1; mem2icTag_i = 53'd18; mem2icIndex_i = 6'd0; mem2icData_i = '1;
        @(negedge clk);
        mem2icRespValid_i = 0;
        n_tests++;
        if ({icMiss_o, ic2memReqValid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL wait_ignores_resp got=%b exp=10", {icMiss_o, ic2memReqValid_o});
        end
        fetch(64'h1000, 4'hf, IGN, 4'h0, 1'b0, 1'b0);
        refill(64'h1000, 1'b0);
        fetch(64'h1000, 4'hf, HIT, 4'hf, 1'b0, 1'b0);
    endtask
    task automatic test_line_end();
        fetch(64'h1018, 4'b1111, HIT, 4'b0011, 1'b0, 1'b0);
        fetch(64'h1018, 4'b0111, HIT, 4'b0011, 1'b0, 1'b0);
        fetch(64'h1018, 4'b0101, HIT, 4'b0001, 1'b0, 1'b0);
    endtask
    task automatic test_back_to_back();
        fetch(64'h1004, 4'b1111, HIT, 4'b1111, 1'b0, 1'b0);
        fetch(64'h1010, 4'b1010, HIT, 4'b1010, 1'b0, 1'b0);
        fetch(64'h1014, 4'b1111, HIT, 4'b0111, 1'b0, 1'b0);
        fetch(64'h101c, 4'b1111, HIT, 4'b0001, 1'b0, 1'b0);
        fetch(64'h1008, 4'b0110, HIT, 4'b0110, 1'b0, 1'b0);
    endtask
    task automatic test_replacement();
        fetch(64'h2020, 4'hf, MISS, 4'h0, 1'b0, 1'b0); refill(64'h2020, 1'b0);
        fetch(64'h4020, 4'hf, MISS, 4'h0, 1'b1, 1'b0); refill(64'h4020, 1'b0);
        fetch(64'h8020, 4'hf, MISS, 4'h0, 1'b0, 1'b0); refill(64'h8020, 1'b0);
        fetch(64'h4020, 4'hf, HIT, 4'hf, 1'b0, 1'b0);
        fetch(64'h8020, 4'hf, HIT, 4'hf, 1'b0, 1'b0);
        fetch(64'h2020, 4'hf, MISS, 4'h0, 1'b1, 1'b0); refill(64'h2020, 1'b0);
        fetch(64'h2020, 4'hf, HIT, 4'hf, 1'b0, 1'b0);
    endtask
    task automatic test_invalidate();
        fetch(64'h1000, 4'hf, HIT, 4'hf, 1'b0, 1'b1);
        fetch(64'h1000, 4'hf, MISS, 4'h0, 1'b1, 1'b0);
        refill(64'h1000, 1'b1);
        fetch(64'h1000, 4'hf, HIT, 4'hf, 1'b0, 1'b0);
    endtask
    task automatic test_flush();
        int k = 0;
        fetch(64'h3000, 4'hf, MISS, 4'h0, 1'b0, 1'b0);
        icFlush_i = 1;
        @(negedge clk);
        icFlush_i = 0;
        refill(64'h3000, 1'b0);
        while (icFlushDone_o !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k != 64) begin
            n_fail++;
            $display("FAIL flush_latency got=%0d cycles exp=64", k);
        end
        @(negedge clk);
        n_tests++;
        if (icFlushDone_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done_pulse got=%b exp=0", icFlushDone_o);
        end
        fetch(64'h3000, 4'hf, MISS, 4'h0, 1'b1, 1'b0); refill(64'h3000, 1'b0);
        fetch(64'h2020, 4'hf, MISS, 4'h0, 1'b0, 1'b0); refill(64'h2020, 1'b0);
        fetch(64'h1000, 4'hf, MISS, 4'h0, 1'b0, 1'b0); refill(64'h1000, 1'b0);
        fetch(64'h2020, 4'hf, HIT, 4'hf, 1'b0, 1'b0);
    endtask
    task automatic test_reset_mid();
        fetch(64'h5000, 4'hf, MISS, 4'h0, 1'b1, 1'b0);
        #1 reset = 0;
        #1;
        n_tests++;
        if ({icMiss_o, ic2memReqValid_o, instValid_o, ic2memReqAddr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs miss=%b req=%b val=%b exp all 0", icMiss_o, ic2memReqValid_o, instValid_o);
        end
        repeat (2) @(negedge clk);
        reset = 1;
        mem2icRespValid_i = 1; mem2icTag_i = 53'd10; mem2icIndex_i = 6'd0; mem2icData_i = line_data(64'h5000);
        @(negedge clk);
        mem2icRespValid_i = 0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if ({icMiss_o, ic2memReqValid_o, instValid_o} !== '0) begin
                n_fail++;
                $display("FAIL stale_resp miss=%b req=%b val=%b exp all 0", icMiss_o, ic2memReqValid_o, instValid_o);
            end
        end
        fetch(64'h2020, 4'hf, MISS, 4'h0, 1'b0, 1'b0);
    endtask
    initial begin
        test_reset();
        test_cold();
        test_line_end();
        test_back_to_back();
        test_replacement();
        test_invalidate();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
